// File: rtl/base_tag_alloc.sv
// base_tag_alloc: free-tag allocator with a registered busy vector and a one-entry offer stage.
// Optional issued-tag counter on o_cnt, enabled by `define BASE_TAG_ALLOC_CNT_EN.
module base_tag_alloc #(
    parameter int a_width = 2,
    parameter int depth   = 1 << a_width
) (
    input  logic               clk,
    input  logic               reset,
    output logic               o_alloc_v,
    output logic [a_width-1:0] o_alloc_tag,
    input  logic               i_alloc_take,
    input  logic               i_free_v,
    input  logic [a_width-1:0] i_free_tag,
    output logic               o_err,
    output logic [a_width:0]   o_cnt
);

    logic [depth-1:0]   busy_q, busy_d;
    logic               stage_v_q, stage_v_d;
    logic [a_width-1:0] stage_tag_q, stage_tag_d;
    logic               err_q, err_d;
    logic               take_s, free_hit_s, free_ok_s, found_s, load_s;
    logic [a_width-1:0] pick_s;

    // Handshake, free legality and lowest-free search over the registered busy vector
    always_comb begin
        take_s     = stage_v_q & i_alloc_take;
        free_hit_s = 1'b0;
        found_s    = 1'b0;
        pick_s     = {a_width{1'b0}};
        for (int i = 0; i < depth; i++) begin
            free_hit_s = free_hit_s | (busy_q[i] & (i_free_tag == a_width'(i)));
        end
        // Staged tags are busy too, so the staged-tag check makes taken-and-freed illegal
        free_ok_s = i_free_v & free_hit_s & ~(stage_v_q & (i_free_tag == stage_tag_q));
        for (int i = depth - 1; i >= 0; i--) begin
            pick_s  = busy_q[i] ? pick_s : a_width'(i);
            found_s = found_s | ~busy_q[i];
        end
        load_s = ~stage_v_q | take_s;
        err_d  = i_free_v & ~free_ok_s;
    end

    // Next busy vector and stage contents
    always_comb begin
        busy_d      = busy_q;
        stage_v_d   = stage_v_q;
        stage_tag_d = stage_tag_q;
        for (int i = 0; i < depth; i++) begin
            busy_d[i] = (busy_q[i] & ~(free_ok_s & (i_free_tag == a_width'(i))))
                      | (load_s & found_s & (pick_s == a_width'(i)));
        end
        if (load_s) begin
            stage_v_d = found_s;
            if (found_s) begin
                stage_tag_d = pick_s;
            end else begin
                stage_tag_d = stage_tag_q;
            end
        end else begin
            stage_v_d = stage_v_q;
        end
    end

    // Allocator state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q      <= {depth{1'b0}};
            stage_v_q   <= 1'b0;
            stage_tag_q <= {a_width{1'b0}};
            err_q       <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            stage_v_q   <= stage_v_d;
            stage_tag_q <= stage_tag_d;
            err_q       <= err_d;
        end
    end

    assign o_alloc_v   = stage_v_q;
    assign o_alloc_tag = stage_tag_q;
    assign o_err       = err_q;

`ifdef BASE_TAG_ALLOC_CNT_EN
    logic [a_width:0] cnt_q, cnt_d;

    // Issued count: a completed take and a legal free in the same cycle cancel
    always_comb begin
        if (take_s && !free_ok_s) begin
            cnt_d = cnt_q + (a_width + 1)'(1);
        end else if (!take_s && free_ok_s) begin
            cnt_d = cnt_q - (a_width + 1)'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Issued-count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= {(a_width + 1){1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;
`else
    assign o_cnt = {(a_width + 1){1'b0}};
`endif

endmodule

// File: tb/tb_base_tag_alloc.sv
// Self-checking bench for base_tag_alloc: set-based reference model plus directed literal checks.
module tb_base_tag_alloc;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          o_alloc_v;
    logic [AW-1:0] o_alloc_tag;
    logic          i_alloc_take;
    logic          i_free_v;
    logic [AW-1:0] i_free_tag;
    logic          o_err;
    logic [AW:0]   o_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: set of issued tags (taken, not yet freed) and the offered tag (-1 = none)
    bit m_issued [DEPTH];
    int m_staged;
    bit m_err;

    base_tag_alloc #(.a_width(AW), .depth(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .o_alloc_v   (o_alloc_v),
        .o_alloc_tag (o_alloc_tag),
        .i_alloc_take(i_alloc_take),
        .i_free_v    (i_free_v),
        .i_free_tag  (i_free_tag),
        .o_err       (o_err),
        .o_cnt       (o_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int issued_count();
        int c = 0;
        for (int t = 0; t < DEPTH; t++) c += int'(m_issued[t]);
        return c;
    endfunction

    function automatic int exp_cnt();
`ifdef BASE_TAG_ALLOC_CNT_EN
        return issued_count();
`else
        return 0;
`endif
    endfunction

    function automatic int lit_cnt(input int n);
`ifdef BASE_TAG_ALLOC_CNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        for (int t = 0; t < DEPTH; t++) m_issued[t] = 1'b0;
        m_staged = -1;
        m_err    = 1'b0;
    endtask

    task automatic model_edge();
        int pick;
        int ft;
        bit legal;
        bit took;
        pick = -1;
        for (int t = DEPTH - 1; t >= 0; t--)
            if (!m_issued[t] && t != m_staged) pick = t;
        ft    = int'(i_free_tag);
        legal = i_free_v && (ft < DEPTH) && m_issued[ft];
        took  = (m_staged >= 0) && i_alloc_take;
        m_err = i_free_v && !legal;
        if (took) m_issued[m_staged] = 1'b1;
        if (legal) m_issued[ft] = 1'b0;
        if (m_staged < 0 || took) m_staged = pick;
    endtask

    task automatic compare();
        chk("alloc_v", int'(o_alloc_v), int'(m_staged >= 0));
        if (m_staged >= 0) chk("alloc_tag", int'(o_alloc_tag), m_staged);
        chk("err", int'(o_err), int'(m_err));
        chk("cnt", int'(o_cnt), exp_cnt());
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_reset();
        else model_edge();
        @(negedge clk);
        compare();
    endtask

    initial begin
        reset        = 1'b0;
        i_alloc_take = 1'b0;
        i_free_v     = 1'b0;
        i_free_tag   = '0;
        model_reset();
        tick();
        tick();
        chk("rst_v", int'(o_alloc_v), 0);
        chk("rst_tag", int'(o_alloc_tag), 0);
        chk("rst_err", int'(o_err), 0);
        chk("rst_cnt", int'(o_cnt), 0);

        // Release: tag 0 staged on the first edge
        reset = 1'b1;
        tick();
        chk("first_v", int'(o_alloc_v), 1);
        chk("first_tag", int'(o_alloc_tag), 0);

        // Back-to-back takes drain the pool
        i_alloc_take = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) chk("burst_tag", int'(o_alloc_tag), k);
            tick();
        end
        chk("drained_v", int'(o_alloc_v), 0);
        chk("drained_cnt", int'(o_cnt), lit_cnt(4));

        // Free tag 2: count drops after one edge, re-offered after two
        i_alloc_take = 1'b0;
        i_free_v     = 1'b1;
        i_free_tag   = 2'd2;
        tick();
        i_free_v = 1'b0;
        chk("free2_cnt", int'(o_cnt), lit_cnt(3));
        chk("free2_v_early", int'(o_alloc_v), 0);
        tick();
        chk("free2_v", int'(o_alloc_v), 1);
        chk("free2_tag", int'(o_alloc_tag), 2);

        // Free 3 -> tags 0,1 issued, 2 staged; hold stage, then illegal free of staged tag
        i_free_v   = 1'b1;
        i_free_tag = 2'd3;
        tick();
        i_free_v = 1'b0;
        tick();
        tick();
        chk("hold_tag", int'(o_alloc_tag), 2);
        i_free_v   = 1'b1;
        i_free_tag = 2'd2;
        tick();
        i_free_v = 1'b0;
        chk("staged_free_err", int'(o_err), 1);
        chk("staged_free_tag", int'(o_alloc_tag), 2);
        chk("staged_free_cnt", int'(o_cnt), lit_cnt(2));
        tick();
        chk("err_one_cycle", int'(o_err), 0);

        // Free never-issued tag 3
        i_free_v   = 1'b1;
        i_free_tag = 2'd3;
        tick();
        i_free_v = 1'b0;
        chk("unissued_err", int'(o_err), 1);
        tick();
        chk("unissued_err_drop", int'(o_err), 0);

        // Take 2 while freeing 1; then take 3 -> tag 1 offered
        i_alloc_take = 1'b1;
        i_free_v     = 1'b1;
        i_free_tag   = 2'd1;
        tick();
        i_free_v = 1'b0;
        chk("tf_cnt", int'(o_cnt), lit_cnt(2));
        chk("tf_tag", int'(o_alloc_tag), 3);
        tick();
        i_alloc_take = 1'b0;
        chk("reoffer1_tag", int'(o_alloc_tag), 1);
        chk("reoffer1_v", int'(o_alloc_v), 1);

        // Take tag 1 and free it in the same cycle: illegal
        i_alloc_take = 1'b1;
        i_free_v     = 1'b1;
        i_free_tag   = 2'd1;
        tick();
        i_alloc_take = 1'b0;
        i_free_v     = 1'b0;
        chk("take_free_same_err", int'(o_err), 1);
        chk("take_free_same_cnt", int'(o_cnt), lit_cnt(4));

        // Fresh start, issue 3 tags, then reset asynchronously mid-cycle
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        i_alloc_take = 1'b1;
        tick();
        tick();
        tick();
        chk("pre_rst_cnt", int'(o_cnt), lit_cnt(3));
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("async_rst_v", int'(o_alloc_v), 0);
        chk("async_rst_tag", int'(o_alloc_tag), 0);
        chk("async_rst_cnt", int'(o_cnt), 0);
        i_alloc_take = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_tag", int'(o_alloc_tag), 0);
        chk("post_rst_v", int'(o_alloc_v), 1);
        chk("post_rst_cnt", int'(o_cnt), 0);

        // Mixed traffic, checked against the model every cycle
        for (int n = 0; n < 200; n++) begin
            i_alloc_take = 1'($urandom_range(0, 1));
            i_free_v     = ($urandom_range(0, 2) == 0);
            i_free_tag   = AW'($urandom_range(0, DEPTH - 1));
            tick();
        end
        i_alloc_take = 1'b0;
        i_free_v     = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
